// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART Tx path (and the future Rx side):
//   - parity-mode encodings used by the PARITY_MODE parameter
//   - transmitter FSM state encoding
//   - frame_bits(): total serial bits in one frame for a given configuration
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Start bit + data bits + optional parity bit + stop bits.
    function automatic int unsigned frame_bits(input int unsigned data_width,
                                               input int unsigned parity_mode,
                                               input int unsigned stop_bits);
        return 1 + data_width + ((parity_mode != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and asserts o_tick
// while the counter holds CLKS_PER_BIT-1, after which it wraps to 0.
// i_restart forces the counter back to 0 on the next edge so a new bit period
// starts aligned to an external event.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   i_restart  synchronous counter restart
//   o_tick     high in the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Parametrised UART transmitter. Accepts one word per valid/ready handshake and
// sends start bit, DATA_WIDTH data bits LSB first, optional parity and
// STOP_BITS stop bits, each lasting CLKS_PER_BIT clocks. Supports line break
// (line held low while idle) and a one-cycle frame-done pulse.
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   i_valid     source presents a word
//   i_data      word to transmit, sampled on accept
//   o_ready     block can accept a word this cycle
//   i_break     request to hold the line low
//   serial_out  registered serial line, idle high
//   o_busy      frame in progress
//   o_done      one-cycle pulse in the first idle cycle after the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    input  logic                  i_break,
    output logic                  serial_out,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int               IDX_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_e             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  done_q, done_d;
    logic                  break_q, break_d;
    logic                  serial_q, serial_d;
    logic                  tick;
    logic                  accept;

    // The counter is held at 0 while idle, so the accept edge starts the
    // start-bit period from count 0.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk       (clk),
        .reset     (reset),
        .i_restart (state_q == IDLE),
        .o_tick    (tick)
    );

    // break_q keeps o_ready low for the release cycle, so a word can only be
    // accepted once the line has been back at idle-high for a cycle.
    assign o_ready = (state_q == IDLE) && !i_break && !break_q && !reset;
    assign accept  = o_ready && i_valid;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        done_d     = 1'b0;
        // Break only takes effect from idle; mid-frame requests wait here.
        break_d    = (state_q == IDLE) && i_break;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    shift_d    = i_data;
                    parity_d   = (^i_data) ^ (PARITY_MODE == PARITY_ODD);
                    idx_d      = '0;
                    stop_idx_d = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        // Shift register: the current data bit is always bit 0.
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line is registered from the next state so it changes on the
        // same edge as the FSM.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = parity_d;
            STOP:    serial_d = 1'b1;
            default: serial_d = !break_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            done_q     <= 1'b0;
            break_q    <= 1'b0;
            serial_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            done_q     <= done_d;
            break_q    <= break_d;
            serial_q   <= serial_d;
        end
    end

    assign serial_out = serial_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
// Three transmitter configurations (even/1 stop, odd/2 stop, no parity/1 stop),
// all 8 data bits at 4 clocks per bit. Expected line levels are queued per
// clock when a word is offered and popped while the frame is observed.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic       brk   = 1'b0;
    logic [7:0] din   = 8'h00;
    logic [1:0] sel   = 2'd0;

    logic [2:0] ready_w, serial_w, busy_w, done_w;
    logic       obs_ready, obs_serial, obs_busy, obs_done;

    int   compared = 0;
    int   failed   = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_core #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_even (
        .clk(clk), .reset(reset), .i_valid(valid && (sel == 2'd0)), .i_data(din),
        .o_ready(ready_w[0]), .i_break(brk && (sel == 2'd0)), .serial_out(serial_w[0]),
        .o_busy(busy_w[0]), .o_done(done_w[0]));

    uart_tx_core #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) u_odd2 (
        .clk(clk), .reset(reset), .i_valid(valid && (sel == 2'd1)), .i_data(din),
        .o_ready(ready_w[1]), .i_break(brk && (sel == 2'd1)), .serial_out(serial_w[1]),
        .o_busy(busy_w[1]), .o_done(done_w[1]));

    uart_tx_core #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_none (
        .clk(clk), .reset(reset), .i_valid(valid && (sel == 2'd2)), .i_data(din),
        .o_ready(ready_w[2]), .i_break(brk && (sel == 2'd2)), .serial_out(serial_w[2]),
        .o_busy(busy_w[2]), .o_done(done_w[2]));

    assign obs_ready  = ready_w[sel];
    assign obs_serial = serial_w[sel];
    assign obs_busy   = busy_w[sel];
    assign obs_done   = done_w[sel];

    task automatic tick();
        @(negedge clk);
    endtask

    // Queue the expected line level for every clock of one frame.
    task automatic push_frame(input logic [7:0] w, input int pm, input int sb);
        logic p;
        p = ^w;
        if (pm == 2) p = ~p;
        for (int c = 0; c < CPB; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) exp_q.push_back(w[i]);
        if (pm != 0)
            for (int c = 0; c < CPB; c++) exp_q.push_back(p);
        for (int c = 0; c < CPB * sb; c++) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            compared++;
            if (obs_serial !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_ready !== 1'b0) begin
                failed++;
                $display("FAIL reset_state dut%0d: got serial=%b busy=%b done=%b ready=%b, want 1 0 0 0",
                         s, obs_serial, obs_busy, obs_done, obs_ready);
            end
        end
        sel   = 2'd0;
        reset = 1'b0;
        tick();
        compared++;
        if (obs_ready !== 1'b1 || obs_serial !== 1'b1) begin
            failed++;
            $display("FAIL reset_release: got ready=%b serial=%b, want 1 1", obs_ready, obs_serial);
        end
    endtask

    task automatic test_frame(input int s, input logic [7:0] w, input int pm, input int sb);
        int   n;
        logic e;
        sel = 2'(s);
        push_frame(w, pm, sb);
        n = exp_q.size();
        #1;
        compared++;
        if (obs_ready !== 1'b1) begin
            failed++;
            $display("FAIL frame_ready dut%0d: got ready=%b, want 1", s, obs_ready);
        end
        valid = 1'b1;
        din   = w;
        tick();
        valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_serial !== e || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
                failed++;
                $display("FAIL frame dut%0d word=%h cycle %0d: got serial=%b busy=%b done=%b, want serial=%b busy=1 done=0",
                         s, w, k, obs_serial, obs_busy, obs_done, e);
            end
            tick();
        end
        compared++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_serial !== 1'b1 || obs_ready !== 1'b1) begin
            failed++;
            $display("FAIL frame_done dut%0d word=%h: got done=%b busy=%b serial=%b ready=%b, want 1 0 1 1",
                     s, w, obs_done, obs_busy, obs_serial, obs_ready);
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        int   accepts;
        logic e;
        sel = 2'd0;
        accepts = 0;
        push_frame(8'h11, 1, 1);
        exp_q.push_back(1'b1);          // done cycle between frames
        push_frame(8'h22, 1, 1);
        n = exp_q.size();
        valid = 1'b1;
        din   = 8'h11;
        #1;
        if (obs_ready && valid) accepts++;
        tick();
        din = 8'h22;
        for (int k = 1; k <= n; k++) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_serial !== e || obs_done !== (k == 45)) begin
                failed++;
                $display("FAIL b2b cycle %0d: got serial=%b done=%b, want serial=%b done=%b",
                         k, obs_serial, obs_done, e, (k == 45));
            end
            if (k == 46) valid = 1'b0;
            if (obs_ready && valid) accepts++;
            tick();
        end
        compared++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0) begin
            failed++;
            $display("FAIL b2b_done: got done=%b busy=%b, want 1 0", obs_done, obs_busy);
        end
        compared++;
        if (accepts !== 2) begin
            failed++;
            $display("FAIL b2b_accepts: got %0d, want 2", accepts);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic saw_done;
        sel   = 2'd0;
        valid = 1'b1;
        din   = 8'h5A;
        tick();
        valid = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        compared++;
        if (obs_serial !== 1'b1 || obs_busy !== 1'b1) begin
            failed++;
            $display("FAIL pre_reset_bit: got serial=%b busy=%b, want 1 1", obs_serial, obs_busy);
        end
        reset = 1'b1;
        tick();
        compared++;
        if (obs_serial !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
            failed++;
            $display("FAIL mid_reset: got serial=%b busy=%b done=%b, want 1 0 0", obs_serial, obs_busy, obs_done);
        end
        reset    = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            saw_done |= obs_done;
        end
        compared++;
        if (saw_done !== 1'b0 || obs_busy !== 1'b0) begin
            failed++;
            $display("FAIL mid_reset_nodone: got done_seen=%b busy=%b, want 0 0", saw_done, obs_busy);
        end
        test_frame(0, 8'h3C, 1, 1);
    endtask

    task automatic test_break();
        int   n;
        logic e;
        sel = 2'd0;
        push_frame(8'h96, 1, 1);
        n = exp_q.size();
        valid = 1'b1;
        din   = 8'h96;
        tick();
        valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k == 8) brk = 1'b1;
            e = exp_q.pop_front();
            compared++;
            if (obs_serial !== e || obs_busy !== 1'b1) begin
                failed++;
                $display("FAIL break_frame cycle %0d: got serial=%b busy=%b, want serial=%b busy=1",
                         k, obs_serial, obs_busy, e);
            end
            tick();
        end
        compared++;
        if (obs_done !== 1'b1 || obs_ready !== 1'b0 || obs_serial !== 1'b1) begin
            failed++;
            $display("FAIL break_done: got done=%b ready=%b serial=%b, want 1 0 1", obs_done, obs_ready, obs_serial);
        end
        valid = 1'b1;
        din   = 8'h00;
        for (int j = 0; j < 5; j++) begin
            tick();
            compared++;
            if (obs_serial !== 1'b0 || obs_ready !== 1'b0 || obs_busy !== 1'b0) begin
                failed++;
                $display("FAIL break_hold %0d: got serial=%b ready=%b busy=%b, want 0 0 0",
                         j, obs_serial, obs_ready, obs_busy);
            end
        end
        brk = 1'b0;
        #1;
        compared++;
        if (obs_ready !== 1'b0) begin
            failed++;
            $display("FAIL break_release_ready: got ready=%b, want 0", obs_ready);
        end
        tick();
        compared++;
        if (obs_serial !== 1'b1 || obs_ready !== 1'b1 || obs_busy !== 1'b0) begin
            failed++;
            $display("FAIL break_after_release: got serial=%b ready=%b busy=%b, want 1 1 0",
                     obs_serial, obs_ready, obs_busy);
        end
        valid = 1'b0;
        tick();
        compared++;
        if (obs_busy !== 1'b0 || obs_serial !== 1'b1) begin
            failed++;
            $display("FAIL break_no_accept: got busy=%b serial=%b, want 0 1", obs_busy, obs_serial);
        end
    endtask

    task automatic test_data_hold();
        int   n;
        logic e;
        sel = 2'd0;
        push_frame(8'hC3, 1, 1);
        n = exp_q.size();
        valid = 1'b1;
        din   = 8'hC3;
        tick();
        valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            din = 8'($urandom);
            e = exp_q.pop_front();
            compared++;
            if (obs_serial !== e) begin
                failed++;
                $display("FAIL data_hold cycle %0d: got serial=%b, want %b", k, obs_serial, e);
            end
            tick();
        end
        compared++;
        if (obs_done !== 1'b1) begin
            failed++;
            $display("FAIL data_hold_done: got done=%b, want 1", obs_done);
        end
    endtask

    initial begin
        test_reset();
        test_frame(0, 8'hA5, 1, 1);
        tick();
        test_frame(1, 8'h01, 2, 2);
        tick();
        test_frame(2, 8'hFF, 0, 1);
        tick();
        test_back_to_back();
        tick();
        test_reset_mid_frame();
        tick();
        test_break();
        tick();
        test_data_hold();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "watchdog expired");
    end

endmodule
